dc_encode_sequencer: RTL and testbench



---
 rtl/dc_seq_pkg.sv | 26 ++
 rtl/dc_cw_fifo.sv | 55 +++++
 rtl/dc_encode_sequencer.sv | 159 +++++++++++++++
 tb/tb_dc_encode_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_seq_pkg.sv
// Shared types and constants for the DC encode sequencer: FSM states, codeword FIFO entry,
// clear length and the largest legal codeword length.
package dc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [31:0] bits;
    logic [5:0]  len;
    logic        last;
  } cw_entry_t;

  localparam int CLEAR_CYCLES = 2;
  localparam int MAX_CW_LEN   = 24;

  function automatic logic len_bad(input logic [31:0] len);
    return (len == 32'd0) || (len > 32'(MAX_CW_LEN));
  endfunction

endpackage

// File: rtl/dc_cw_fifo.sv
// Synchronous codeword FIFO with count/full/empty; head is readable the cycle after its push.
// Pop when empty is ignored; push when full is accepted only alongside a pop.
module dc_cw_fifo
  import dc_seq_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  cw_entry_t        push_dat,
  input  logic             pop,
  output cw_entry_t        head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cw_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero while empty so the writer-facing outputs sit at their reset values.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dc_encode_sequencer.sv
// Streams one slice of DC coefficients into the encoder and queues its codewords for the writer.
// Last push at start+4+N+ENC_LATENCY; writer stalls absorbed by FIFO; DC_SEQ_LEN_CHECK_EN adds len_err.
module dc_encode_sequencer
  import dc_seq_pkg::*;
#(
  parameter int MAX_BLOCKS  = 32,
  parameter int ENC_LATENCY = 5,
  parameter int FIFO_DEPTH  = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_blocks,
  output logic              busy,
  output logic              done,
  output logic              coef_rd,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [31:0]       coef_rdata,
  output logic              enc_clr_n,
  output logic [31:0]       enc_dc_coeff,
  input  logic [31:0]       enc_sum,
  input  logic [31:0]       enc_length,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [31:0]       cw_bits,
  output logic [5:0]        cw_len,
  output logic              cw_last,
  output logic              len_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  seq_state_t        state;
  logic [ADDR_W:0]   n_blk;
  logic [1:0]        clr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              start_ok;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic [ENC_LATENCY:0] tok_vld;
  logic [ENC_LATENCY:0] tok_last;
  logic              push;
  cw_entry_t         push_dat;
  cw_entry_t         head_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              unused_fifo_full;

  assign last_addr = ADDR_W'(n_blk - 1'b1);
  assign busy      = (state != IDLE);

  // Every slice's codewords must fit behind what is already queued, so capture never stalls.
  assign start_ok = start && (num_blocks != '0)
                 && (32'(num_blocks) <= 32'(MAX_BLOCKS))
                 && ((32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(num_blocks));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      n_blk     <= '0;
      clr_cnt   <= '0;
      coef_rd   <= 1'b0;
      coef_addr <= '0;
      enc_clr_n <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      enc_clr_n <= 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            n_blk     <= num_blocks;
            clr_cnt   <= '0;
            enc_clr_n <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == 2'(CLEAR_CYCLES - 1)) begin
            coef_rd   <= 1'b1;
            coef_addr <= '0;
            state     <= ISSUE;
          end else begin
            clr_cnt   <= clr_cnt + 1'b1;
            enc_clr_n <= 1'b0;
          end
        end
        ISSUE: begin
          if (coef_addr == last_addr) begin
            coef_rd <= 1'b0;
            state   <= WAIT;
          end else begin
            coef_addr <= coef_addr + 1'b1;
          end
        end
        WAIT: begin
          if (tok_vld[ENC_LATENCY] && tok_last[ENC_LATENCY]) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tokens start alongside enc_dc_coeff and emerge the cycle enc_sum/enc_length belong to them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      enc_dc_coeff <= '0;
      tok_vld      <= '0;
      tok_last     <= '0;
    end else begin
      rd_vld_q  <= coef_rd;
      rd_last_q <= coef_rd && (coef_addr == last_addr);
      if (rd_vld_q) enc_dc_coeff <= coef_rdata;
      tok_vld  <= {tok_vld[ENC_LATENCY-1:0], rd_vld_q};
      tok_last <= {tok_last[ENC_LATENCY-1:0], rd_vld_q && rd_last_q};
    end
  end

  assign push     = tok_vld[ENC_LATENCY];
  assign push_dat = '{bits: enc_sum, len: enc_length[5:0], last: tok_last[ENC_LATENCY]};

  dc_cw_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (cw_valid && cw_ready),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (unused_fifo_full),
    .empty    (fifo_empty)
  );

  assign cw_valid = !fifo_empty;
  assign cw_bits  = head_dat.bits;
  assign cw_len   = head_dat.len;
  assign cw_last  = head_dat.last;

`ifdef DC_SEQ_LEN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          len_err <= 1'b0;
    else if (push && len_bad(enc_length))  len_err <= 1'b1;
  end
`else
  logic unused_len_hi;
  assign unused_len_hi = ^enc_length[31:6];
  assign len_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dc_encode_sequencer.sv
// Directed bench: coefficient buffer and fixed-latency encoder models, a slice-level codeword
// scoreboard checked on every pop, and literal timing expectations.
module tb_dc_encode_sequencer;

  typedef struct {
    logic [31:0] bits;
    logic [5:0]  len;
    logic        last;
  } exp_cw_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  num_blocks;
  logic        busy, done, coef_rd;
  logic [4:0]  coef_addr;
  logic [31:0] coef_rdata;
  logic        enc_clr_n;
  logic [31:0] enc_dc_coeff, enc_sum, enc_length;
  logic        cw_valid, cw_ready, cw_last, len_err;
  logic [31:0] cw_bits;
  logic [5:0]  cw_len;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          clr_low_cnt = 0;
  logic        force_len = 1'b0;
  logic [31:0] coef_mem [32];
  logic [31:0] pipe_s [5];
  logic [31:0] pipe_l [5];
  exp_cw_t     exp_q [$];
  logic [31:0] pop_bits [$];
  logic [5:0]  pop_len [$];
  logic        pop_last [$];
`ifdef DC_SEQ_LEN_CHECK_EN
  localparam logic LEN_ERR_EXP = 1'b1;
`else
  localparam logic LEN_ERR_EXP = 1'b0;
`endif

  dc_encode_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .coef_rd(coef_rd), .coef_addr(coef_addr),
    .coef_rdata(coef_rdata), .enc_clr_n(enc_clr_n), .enc_dc_coeff(enc_dc_coeff),
    .enc_sum(enc_sum), .enc_length(enc_length), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .cw_bits(cw_bits), .cw_len(cw_len), .cw_last(cw_last),
    .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] enc_bits_f(input logic [31:0] c);
    return c * 32'd3 + 32'd1;
  endfunction

  function automatic logic [31:0] enc_len_f(input logic [31:0] c, input logic frc);
    return frc ? 32'd25 : {28'd0, c[3:0]} + 32'd1;
  endfunction

  // Coefficient buffer: one-cycle read latency.
  always @(posedge clk) if (coef_rd) coef_rdata <= coef_mem[coef_addr];

  // Encoder: result for the value sampled at edge E is presented for sampling at E+5.
  always @(posedge clk) begin
    pipe_s[0] <= enc_bits_f(enc_dc_coeff);
    pipe_l[0] <= enc_len_f(enc_dc_coeff, force_len);
    for (int i = 4; i > 0; i--) begin
      pipe_s[i] <= pipe_s[i-1];
      pipe_l[i] <= pipe_l[i-1];
    end
  end
  assign enc_sum    = pipe_s[4];
  assign enc_length = pipe_l[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted head must be the next expected codeword.
  always @(negedge clk) begin
    if (reset_n && cw_valid && cw_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop actual=%0h required=none", cw_bits);
      end else begin
        exp_cw_t e;
        e = exp_q.pop_front();
        check("pop_bits", cw_bits, e.bits);
        check("pop_len", cw_len, e.len);
        check("pop_last", cw_last, e.last);
      end
      pop_bits.push_back(cw_bits);
      pop_len.push_back(cw_len);
      pop_last.push_back(cw_last);
    end
  end

  always @(negedge clk) if (reset_n && !enc_clr_n) clr_low_cnt = clr_low_cnt + 1;

  task automatic load_slice(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      exp_cw_t     e;
      logic [31:0] c, l;
      c = 32'(base + i * step);
      coef_mem[i] = c;
      l = enc_len_f(c, force_len);
      e.bits = enc_bits_f(c);
      e.len  = l[5:0];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int n, output int t0);
    @(posedge clk); #2;
    num_blocks = 6'(n);
    start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int exp_off, input string name);
    int td = -1;
    for (int i = 0; i < 100 && td < 0; i++) begin
      @(negedge clk);
      if (done) td = cyc;
    end
    check(name, td, t0 + exp_off);
  endtask

  task automatic drain(input int budget, input string name);
    cw_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ctl"}, {busy, done, coef_rd, coef_addr, enc_clr_n, cw_valid, cw_last, len_err}, 0);
    check({tag, "_coeff"}, enc_dc_coeff, 0);
    check({tag, "_cw"}, {cw_bits, cw_len}, 0);
  endtask

  function automatic logic [31:0] last_pattern();
    logic [31:0] p = '0;
    foreach (pop_last[i]) p[i] = pop_last[i];
    return p;
  endfunction

  function automatic void clear_logs();
    pop_bits.delete();
    pop_len.delete();
    pop_last.delete();
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tv;
    reset_n = 1'b0; start = 1'b0; num_blocks = '0; cw_ready = 1'b0;
    foreach (coef_mem[i]) coef_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_n_after_reset", enc_clr_n, 1);
    check("idle_busy", busy, 0);

    // Single slice, N=4, coefficients 0x40.
    cw_ready = 1'b1;
    load_slice(4, 32'h40, 0);
    do_start(4, t0);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    tv = -1;
    for (int i = 0; i < 40 && tv < 0; i++) begin
      if (cw_valid) tv = cyc;
      else @(negedge clk);
    end
    check("first_push_edge", tv, t0 + 10);
    wait_done(t0, 13, "done_n4");
    drain(20, "drain_n4");
    check("pops_n4", pop_bits.size(), 4);
    check("last_pattern_n4", last_pattern(), 32'b1000);
    check("lit_bits_0x40", pop_bits[0], 32'hC1);
    check("lit_len_0x40", pop_len[0], 1);

    // Backpressure, N=8.
    clear_logs();
    cw_ready = 1'b0;
    load_slice(8, 7, 5);
    do_start(8, t0);
    wait_done(t0, 17, "done_n8");
    repeat (25) @(negedge clk);
    check("no_pop_stalled", pop_bits.size(), 0);
    check("held_valid", cw_valid, 1);
    drain(40, "drain_n8");
    check("pops_n8", pop_bits.size(), 8);
    check("lit_bits_12", pop_bits[1], 32'h25);
    check("lit_len_12", pop_len[1], 13);

    // Admission: 28 queued entries leave room for 4, not 8.
    clear_logs();
    cw_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      load_slice((s == 3) ? 4 : 8, 100 + 16 * s, 1);
      do_start((s == 3) ? 4 : 8, t0);
      wait_done(t0, 4 + ((s == 3) ? 4 : 8) + 5, "done_fill");
    end
    do_start(8, t0);
    repeat (3) begin
      @(negedge clk);
      check("rejected_busy", busy, 0);
    end
    @(posedge clk); #2 cw_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 cw_ready = 1'b0;
    @(negedge clk);
    check("pops_after_four", pop_bits.size(), 4);
    load_slice(8, 200, 3);
    do_start(8, t0);
    @(negedge clk);
    check("retry_busy", busy, 1);
    wait_done(t0, 17, "done_retry");
    drain(60, "drain_admission");
    check("pops_admission", pop_bits.size(), 36);

    // Back-to-back slices N=2 then N=3.
    clear_logs();
    cw_ready = 1'b1;
    load_slice(2, 3, 6);
    do_start(2, t0);
    wait_done(t0, 11, "done_b2b_first");
    load_slice(3, 20, 1);
    clr_low_cnt = 0;
    do_start(3, t1);
    check("b2b_start_gap", t1 - t0, 13);
    wait_done(t1, 12, "done_b2b_second");
    check("b2b_clear_cycles", clr_low_cnt, 2);
    drain(20, "drain_b2b");
    check("last_pattern_b2b", last_pattern(), 32'b10010);

    // Reset during the second read of an N=6 slice.
    clear_logs();
    load_slice(6, 50, 2);
    do_start(6, t0);
    tv = -1;
    for (int i = 0; i < 20 && tv < 0; i++) begin
      @(negedge clk);
      if (coef_rd && coef_addr == 5'd1) tv = cyc;
    end
    check("second_read_seen", tv, t0 + 3);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_rst("midreset");
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_pops", pop_bits.size(), 0);
    check("post_reset_valid", cw_valid, 0);
    check("post_reset_busy", busy, 0);

    // Out-of-range length is queued unchanged; len_err only when the checker is built.
    clear_logs();
    force_len = 1'b1;
    cw_ready = 1'b1;
    load_slice(2, 5, 1);
    do_start(2, t0);
    while (cyc < t0 + 9) @(negedge clk);
    check("len_err_before", len_err, 0);
    @(negedge clk);
    check("len_err_after", len_err, LEN_ERR_EXP);
    wait_done(t0, 11, "done_len");
    drain(20, "drain_len");
    force_len = 1'b0;
    repeat (3) @(negedge clk);
    check("len_err_sticky", len_err, LEN_ERR_EXP);
    check("lit_len_25", pop_len[0], 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
